// File: rtl/spi_clk_gen_if.sv
// Interface between spi_clk_gen and its neighbours: the transfer framing
// from the shift register plus the generated clock, edge strobes and busy.
interface spi_clk_gen_if #(
  parameter int DIV_WIDTH = 16
);
  logic                 enable;
  logic                 last;
  logic [DIV_WIDTH-1:0] divider;
  logic                 sclk;
  logic                 cpol_1;
  logic                 cpol_0;
  logic                 busy;

  // Side driving the framing and divider (shift register / bench)
  modport master (
    output enable, last, divider,
    input  sclk, cpol_1, cpol_0, busy
  );

  // Clock generator side
  modport slave (
    input  enable, last, divider,
    output sclk, cpol_1, cpol_0, busy
  );
endinterface

// File: rtl/spi_clk_gen.sv
// SPI serial clock generator. Divides wb_clk_in by 2*(divider+1) while a
// transfer is in progress and emits one-cycle strobes on each sclk edge.
// Transfers end only on a falling toggle, so sclk always parks low.
module spi_clk_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic          wb_clk_in,
  input  logic          wb_rst,
  spi_clk_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q,   cnt_d;
  logic                 sclk_q,  sclk_d;
  logic                 cpol1_q, cpol1_d;
  logic                 cpol0_q, cpol0_d;
  logic                 busy_q,  busy_d;

  // Next-state, counter and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sclk_d  = sclk_q;
    cpol1_d = 1'b0;
    cpol0_d = 1'b0;
    case (state_q)
      IDLE: begin
        sclk_d = 1'b0;
        if (bus.enable) begin
          state_d = RUN;
          cnt_d   = bus.divider;
        end
      end
      RUN: begin
        if (!bus.enable) begin
          // Abort: drop the clock immediately, no edge strobe.
          state_d = IDLE;
          sclk_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end else begin
          // Half-period elapsed: toggle and pick up the current divider.
          sclk_d = ~sclk_q;
          cnt_d  = bus.divider;
          if (!sclk_q) begin
            cpol1_d = 1'b1;
          end else begin
            cpol0_d = 1'b1;
            // last only matters on a falling toggle so sclk ends low.
            if (bus.last) state_d = STOP;
          end
        end
      end
      STOP: begin
        sclk_d  = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        sclk_d  = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge wb_clk_in) begin
    if (wb_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sclk_q  <= 1'b0;
      cpol1_q <= 1'b0;
      cpol0_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sclk_q  <= sclk_d;
      cpol1_q <= cpol1_d;
      cpol0_q <= cpol0_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.sclk   = sclk_q;
  assign bus.cpol_1 = cpol1_q;
  assign bus.cpol_0 = cpol0_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_spi_clk_gen.sv
// Directed bench for spi_clk_gen. Expected per-cycle outputs are derived
// from the toggle schedule each scenario should produce and queued before
// the clock edge; each edge pops one entry and compares.
module tb_spi_clk_gen;

  typedef struct packed {
    logic sclk;
    logic c1;
    logic c0;
    logic busy;
  } obs_t;

  logic wb_clk_in = 1'b0;
  logic wb_rst    = 1'b1;

  spi_clk_gen_if #(.DIV_WIDTH(16)) bus ();

  spi_clk_gen #(.DIV_WIDTH(16)) dut (
    .wb_clk_in (wb_clk_in),
    .wb_rst    (wb_rst),
    .bus       (bus)
  );

  always #5 wb_clk_in = ~wb_clk_in;

  obs_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Advance one edge, then compare DUT outputs with the oldest expectation.
  task automatic cycle(input string tag);
    obs_t e, o;
    @(posedge wb_clk_in);
    #1;
    o = '{bus.sclk, bus.cpol_1, bus.cpol_0, bus.busy};
    n_chk++;
    if (sb.size() == 0) begin
      $error("FAIL %s: scoreboard empty, got %b", tag, o);
    end else begin
      e = sb.pop_front();
      assert (o === e) n_pass++;
      else $error("FAIL %s: sclk/c1/c0/busy got %b want %b", tag, o, e);
    end
  endtask

  // Expect n cycles of idle outputs.
  task automatic expect_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      sb.push_back(obs_t'(4'b0000));
      cycle(tag);
    end
  endtask

  // Expect a running transfer for edges n0..n1 after enable is sampled
  // (edge 0). tg lists the edges at which sclk toggles.
  task automatic run_sched(input string tag, input int n0, input int n1,
                           input int tg[$]);
    for (int n = n0; n <= n1; n++) begin
      int   k;
      bit   hit;
      obs_t e;
      k   = 0;
      hit = 1'b0;
      foreach (tg[i]) begin
        if (tg[i] <= n) k++;
        if (tg[i] == n) hit = 1'b1;
      end
      e.sclk = k[0];
      e.c1   = hit && k[0];
      e.c0   = hit && !k[0];
      e.busy = 1'b1;
      sb.push_back(e);
      cycle(tag);
    end
  endtask

  task automatic mk_tg(output int q[$], input int first, input int step,
                       input int cnt);
    q = {};
    for (int i = 0; i < cnt; i++) q.push_back(first + i * step);
  endtask

  task automatic do_reset();
    wb_rst     = 1'b1;
    bus.enable = 1'b0;
    bus.last   = 1'b0;
    sb.push_back(obs_t'(4'b0000));
    cycle("reset");
    wb_rst = 1'b0;
  endtask

  initial begin
    int tg[$];
    bus.enable  = 1'b0;
    bus.last    = 1'b0;
    bus.divider = 16'd1;

    // Reset state, and idle with enable low stays idle
    do_reset();
    expect_idle("idle_no_en", 2);

    // 1: divider=1, free running, period 4
    bus.divider = 16'd1;
    bus.enable  = 1'b1;
    mk_tg(tg, 2, 2, 6);
    run_sched("div1_run", 0, 12, tg);

    // 2: last seen at the 4th rise is ignored; 4th fall ends the transfer
    do_reset();
    bus.divider = 16'd1;
    bus.enable  = 1'b1;
    mk_tg(tg, 2, 2, 8);
    run_sched("last_pre", 0, 12, tg);
    bus.last = 1'b1;
    run_sched("last_end", 13, 16, tg);
    bus.enable = 1'b0;
    bus.last   = 1'b0;
    expect_idle("last_idle", 3);

    // 3: divider=0 toggles every cycle, strobes alternate
    do_reset();
    bus.divider = 16'd0;
    bus.enable  = 1'b1;
    mk_tg(tg, 1, 1, 10);
    run_sched("div0_run", 0, 10, tg);

    // 4: divider=3, abort 2 cycles after the 2nd rise
    do_reset();
    bus.divider = 16'd3;
    bus.enable  = 1'b1;
    mk_tg(tg, 4, 4, 3);
    run_sched("abort_run", 0, 14, tg);
    bus.enable = 1'b0;
    expect_idle("abort_idle", 3);

    // 5: divider 2 -> 5 mid half-period applies at next reload
    do_reset();
    bus.divider = 16'd2;
    bus.enable  = 1'b1;
    tg = '{3, 6, 9, 15, 21, 27};
    run_sched("divchg_a", 0, 7, tg);
    bus.divider = 16'd5;
    run_sched("divchg_b", 8, 28, tg);

    // 6: reset mid-transfer with sclk high, then restart with enable held
    do_reset();
    bus.divider = 16'd1;
    bus.enable  = 1'b1;
    tg = '{2};
    run_sched("rst_mid_a", 0, 2, tg);
    wb_rst = 1'b1;
    sb.push_back(obs_t'(4'b0000));
    cycle("rst_mid");
    wb_rst = 1'b0;
    mk_tg(tg, 2, 2, 3);
    run_sched("rst_mid_b", 0, 6, tg);

    // 7: enable held through STOP re-arms one cycle later
    do_reset();
    bus.divider = 16'd0;
    bus.enable  = 1'b1;
    bus.last    = 1'b1;
    tg = '{1, 2};
    run_sched("rearm_a", 0, 2, tg);
    expect_idle("rearm_stop", 1);
    tg = '{1};
    run_sched("rearm_b", 0, 1, tg);
    bus.enable = 1'b0;
    bus.last   = 1'b0;
    expect_idle("rearm_abort", 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
